// File: rtl/key_pkg.sv
// key_pkg
// Shared constants and types for the key scanning front end.
//   KEY_DEB_CYCLES   : default debounce window in sys_clk cycles (20 ms at 250 MHz)
//   KEY_TICK_DIV     : default prescaler period in sys_clk cycles (1 ms tick)
//   KEY_LONG_TICKS   : default number of ticks before a long press is reported
//   KEY_REPEAT_TICKS : default auto-repeat period in ticks
//   hold_state_e     : per-channel hold state machine encoding
package key_pkg;

    localparam int KEY_DEB_CYCLES   = 5_000_000;
    localparam int KEY_TICK_DIV     = 250_000;
    localparam int KEY_LONG_TICKS   = 1000;
    localparam int KEY_REPEAT_TICKS = 200;

    typedef enum logic [1:0] {
        HOLD_IDLE    = 2'd0,
        HOLD_PRESSED = 2'd1,
        HOLD_HELD    = 2'd2
    } hold_state_e;

endpackage

// File: rtl/key_chan_filter.sv
// key_chan_filter
// One key channel: two-flop synchroniser, debounce counter and registered
// press/release strobes.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   key_i           : raw asynchronous key pin
//   filter_o        : debounced level, same polarity as key_i (registered)
//   press_o         : 1-cycle strobe on idle->pressed (registered)
//   release_o       : 1-cycle strobe on pressed->idle (registered)
//   press_evt_o     : next-cycle value of press_o, lets the hold FSM act on
//                     the same edge that press_o rises
//   release_evt_o   : next-cycle value of release_o, same purpose
// Strobes carry no handshake: a pulse is valid for exactly the one cycle it
// is high and the consumer cannot stall it.
module key_chan_filter
    import key_pkg::*;
#(
    parameter int CNT_MAX    = KEY_DEB_CYCLES,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    output logic filter_o,
    output logic press_o,
    output logic release_o,
    output logic press_evt_o,
    output logic release_evt_o
);

    localparam int              CW        = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0]   CNT_LOAD  = CW'(CNT_MAX);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic            IDLE_LVL  = ACTIVE_LOW;

    logic          d0_q, d1_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;
    logic          out_filt_q;
    logic          press_q, release_q;
    logic          press_d, release_d;

    always_comb begin
        cnt_d = cnt_q;
        if (d1_q != d0_q) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // filt_q is the debounced level one stage before the outputs; the
    // output stage below compares against it, so filter_o and its edge
    // strobe rise on the same edge, CNT_MAX+2 edges after d0 first samples
    // the new level.
    always_comb begin
        filt_d = filt_q;
        if (cnt_q == CNT_ONE) begin
            filt_d = d1_q;
        end
    end

    always_comb begin
        press_d   = 1'b0;
        release_d = 1'b0;
        if (filt_q != out_filt_q) begin
            press_d   = (filt_q != IDLE_LVL);
            release_d = (filt_q == IDLE_LVL);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d0_q       <= IDLE_LVL;
            d1_q       <= IDLE_LVL;
            cnt_q      <= '0;
            filt_q     <= IDLE_LVL;
            out_filt_q <= IDLE_LVL;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
        end else begin
            d0_q       <= key_i;
            d1_q       <= d0_q;
            cnt_q      <= cnt_d;
            filt_q     <= filt_d;
            out_filt_q <= filt_q;
            press_q    <= press_d;
            release_q  <= release_d;
        end
    end

    assign filter_o      = out_filt_q;
    assign press_o       = press_q;
    assign release_o     = release_q;
    assign press_evt_o   = press_d;
    assign release_evt_o = release_d;

endmodule

// File: rtl/key_scan_multi.sv
// key_scan_multi
// Multi-channel push-button front end: per-channel debounce plus a shared
// tick prescaler driving per-channel hold state machines (long press,
// held level, auto-repeat). Everything is in the sys_clk domain and every
// output is registered.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   key                : raw key pins, NUM_KEYS wide
//   key_filter         : debounced level, same polarity as key
//   key_press          : 1-cycle strobe on debounced idle->pressed
//   key_release        : 1-cycle strobe on debounced pressed->idle
//   key_held           : level, high from long press until release
//   key_long           : 1-cycle strobe when the long-press threshold is hit
//   key_repeat         : 1-cycle strobe every REPEAT_TICKS ticks while held
module key_scan_multi
    import key_pkg::*;
#(
    parameter int NUM_KEYS     = 4,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int CNT_MAX      = KEY_DEB_CYCLES,
    parameter int TICK_DIV     = KEY_TICK_DIV,
    parameter int LONG_TICKS   = KEY_LONG_TICKS,
    parameter int REPEAT_TICKS = KEY_REPEAT_TICKS,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] key_filter,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_repeat
);

    localparam int            TW        = $clog2(TICK_DIV + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam int            HW        = $clog2(LONG_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LIM  = HW'(LONG_TICKS);
    localparam int            RW        = $clog2(REPEAT_TICKS + 1);
    localparam logic [RW-1:0] REP_LIM   = RW'(REPEAT_TICKS);

    // Shared free-running prescaler; its phase is independent of any key.
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;

    assign tick = (tick_cnt_q == TICK_LAST);

    always_comb begin
        tick_cnt_d = tick_cnt_q + TW'(1);
        if (tick) begin
            tick_cnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
        logic          press_evt, release_evt;
        hold_state_e   state_q, state_d;
        logic [HW-1:0] hold_cnt_q, hold_cnt_d, hold_inc;
        logic [RW-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
        logic          held_q, held_d;
        logic          long_q, long_d;
        logic          rep_q, rep_d;

        key_chan_filter #(
            .CNT_MAX    (CNT_MAX),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_filter (
            .clk_i         (sys_clk),
            .rst_ni        (sys_rst_n),
            .key_i         (key[g]),
            .filter_o      (key_filter[g]),
            .press_o       (key_press[g]),
            .release_o     (key_release[g]),
            .press_evt_o   (press_evt),
            .release_evt_o (release_evt)
        );

        assign hold_inc = hold_cnt_q + HW'(1);
        assign rep_inc  = rep_cnt_q + RW'(1);

        // Release is checked before any tick handling so that a release
        // landing on a tick edge suppresses that edge's long/repeat strobe.
        always_comb begin
            state_d    = state_q;
            hold_cnt_d = hold_cnt_q;
            rep_cnt_d  = rep_cnt_q;
            held_d     = held_q;
            long_d     = 1'b0;
            rep_d      = 1'b0;
            if (release_evt) begin
                state_d    = HOLD_IDLE;
                hold_cnt_d = '0;
                rep_cnt_d  = '0;
                held_d     = 1'b0;
            end else begin
                unique case (state_q)
                    HOLD_IDLE: begin
                        if (press_evt) begin
                            hold_cnt_d = '0;
                            state_d    = HOLD_PRESSED;
                        end
                    end
                    HOLD_PRESSED: begin
                        if (tick) begin
                            hold_cnt_d = hold_inc;
                            if (hold_inc == HOLD_LIM) begin
                                long_d    = 1'b1;
                                held_d    = 1'b1;
                                rep_cnt_d = '0;
                                state_d   = HOLD_HELD;
                            end
                        end
                    end
                    HOLD_HELD: begin
                        if (tick) begin
                            rep_cnt_d = rep_inc;
                            if (rep_inc == REP_LIM) begin
                                rep_cnt_d = '0;
                                rep_d     = REPEAT_EN;
                            end
                        end
                    end
                    default: begin
                        state_d = HOLD_IDLE;
                    end
                endcase
            end
        end

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                state_q    <= HOLD_IDLE;
                hold_cnt_q <= '0;
                rep_cnt_q  <= '0;
                held_q     <= 1'b0;
                long_q     <= 1'b0;
                rep_q      <= 1'b0;
            end else begin
                state_q    <= state_d;
                hold_cnt_q <= hold_cnt_d;
                rep_cnt_q  <= rep_cnt_d;
                held_q     <= held_d;
                long_q     <= long_d;
                rep_q      <= rep_d;
            end
        end

        assign key_held[g]   = held_q;
        assign key_long[g]   = long_q;
        assign key_repeat[g] = rep_q;
    end

endmodule

// File: tb/tb_key_scan_multi.sv
module tb_key_scan_multi;

    localparam int W = 77;  // {rel[76], lo[75:44], hi[43:12], value[11:0]}

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] key;
    logic [1:0] key_filter, key_press, key_release, key_held, key_long, key_repeat;

    key_scan_multi #(
        .NUM_KEYS     (2),
        .ACTIVE_LOW   (1'b1),
        .CNT_MAX      (8),
        .TICK_DIV     (4),
        .LONG_TICKS   (3),
        .REPEAT_TICKS (2),
        .REPEAT_EN    (1'b1)
    ) dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .key         (key),
        .key_filter  (key_filter),
        .key_press   (key_press),
        .key_release (key_release),
        .key_held    (key_held),
        .key_long    (key_long),
        .key_repeat  (key_repeat)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_tests  = 0;
    int n_fail   = 0;
    int last_evt = 0;

    // value order: {filter, press, release, held, long, repeat}
    function automatic logic [11:0] mkv(logic [1:0] f, logic [1:0] p, logic [1:0] r,
                                        logic [1:0] h, logic [1:0] l, logic [1:0] rp);
        return {f, p, r, h, l, rp};
    endfunction

    // rel=1: lo/hi are offsets from the previous observed event
    function automatic logic [W-1:0] mke(logic rel, int lo, int hi, logic [11:0] v);
        return {rel, lo, hi, v};
    endfunction

    always @(negedge clk) begin
        logic [11:0]  obs;
        logic [W-1:0] e;
        int           lo, hi;
        if (rst_n === 1'b1 && (|{key_press, key_release, key_long, key_repeat})) begin
            obs = {key_filter, key_press, key_release, key_held, key_long, key_repeat};
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event cyc=%0d got=%b", cyc, obs);
            end else begin
                e  = exp_q.pop_front();
                lo = int'(e[75:44]);
                hi = int'(e[43:12]);
                if (e[76]) begin
                    lo += last_evt;
                    hi += last_evt;
                end
                n_tests++;
                if (cyc < lo || cyc > hi) begin
                    n_fail++;
                    $display("FAIL event_time cyc=%0d required %0d..%0d value=%b", cyc, lo, hi, obs);
                end
                n_tests++;
                if (obs !== e[11:0]) begin
                    n_fail++;
                    $display("FAIL event_value cyc=%0d got=%b required=%b", cyc, obs, e[11:0]);
                end
                last_evt = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [11:0] got, input logic [11:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s got=%b required=%b", name, got, req);
        end
    endtask

    task automatic wait_long(output int lc);
        lc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (key_long[0] === 1'b1) begin
                lc = cyc;
                break;
            end
        end
        if (lc < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL long_timeout cyc=%0d got=none required=key_long within 40 cycles", cyc);
            lc = cyc;
        end
    endtask

    function automatic logic [11:0] outs();
        return {key_filter, key_press, key_release, key_held, key_long, key_repeat};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int n0, n1, n2, l1, l2, l3;
        rst_n = 1'b0;
        key   = 2'b11;
        step(3);
        chk("reset_outputs", outs(), mkv(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        rst_n = 1'b1;
        step(5);

        // Clean press, long hold, repeats, glitch, release on a tick edge
        n0 = cyc;
        key[0] = 1'b0;
        exp_q.push_back(mke(1'b0, n0 + 11, n0 + 11, mkv(2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00)));
        exp_q.push_back(mke(1'b0, n0 + 20, n0 + 23, mkv(2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00)));
        exp_q.push_back(mke(1'b1, 8, 8, mkv(2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01)));
        wait_long(l1);
        exp_q.push_back(mke(1'b1, 8, 8, mkv(2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01)));
        // l1 is a tick edge; l1+24 is both a tick and a repeat slot
        exp_q.push_back(mke(1'b0, l1 + 24, l1 + 24, mkv(2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00)));
        step(1);
        key[0] = 1'b1;          // 5-cycle glitch while held
        step(5);
        key[0] = 1'b0;
        step(7);
        key[0] = 1'b1;          // release, filter updates at l1+24
        step(15);
        chk("idle_after_release", outs(), mkv(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));

        // Bounce: toggle every 3 cycles for 24 cycles, settle low
        n1 = cyc;
        exp_q.push_back(mke(1'b0, n1 + 35, n1 + 35, mkv(2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00)));
        exp_q.push_back(mke(1'b0, n1 + 44, n1 + 47, mkv(2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00)));
        exp_q.push_back(mke(1'b1, 8, 8, mkv(2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01)));
        for (int i = 0; i < 8; i++) begin
            key[0] = i[0];
            step(3);
        end
        key[0] = 1'b0;
        wait_long(l2);
        key[0] = 1'b1;
        exp_q.push_back(mke(1'b0, l2 + 11, l2 + 11, mkv(2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00)));
        step(20);

        // Both channels pressed in the same cycle
        n2 = cyc;
        key = 2'b00;
        exp_q.push_back(mke(1'b0, n2 + 11, n2 + 11, mkv(2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00)));
        exp_q.push_back(mke(1'b0, n2 + 20, n2 + 23, mkv(2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00)));
        wait_long(l3);
        step(2);
        chk("held_before_reset", outs(), mkv(2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00));

        // Reset mid-hold, then keys idle
        rst_n = 1'b0;
        key   = 2'b11;
        #1;
        chk("reset_mid_hold", outs(), mkv(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        step(3);
        rst_n = 1'b1;
        step(30);
        chk("idle_after_reset", outs(), mkv(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events got=%0d required=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
